// File: rtl/counter_checker_if.sv
// Observation bundle for the 4-bit up-counter: its reset, its shortcut
// request and its count output. The counter (or harness) is the master.
// The checker only ever listens through the slave modport.
interface counter_checker_if #(
    parameter int W = 4
);
    logic         dut_rst_n;
    logic         shortcut;
    logic [W-1:0] cnt;

    modport master (
        output dut_rst_n,
        output shortcut,
        output cnt
    );

    modport slave (
        input dut_rst_n,
        input shortcut,
        input cnt
    );
endinterface : counter_checker_if

// File: rtl/counter_checker.sv
// counter_checker: passive monitor for the 4-bit up-counter with reset and
// shortcut-to-max. It predicts each output from the previous sample and
// latches diagnostics for the first mismatch. It also counts the increment
// wraps it observes, from all-ones to zero.
// Optional build macro COUNTER_CHECKER_ASSERT_EN adds immediate assertions
// (TRACK state only) and cover points. Register-based reporting is the same
// whether or not the macro is defined.
module counter_checker #(
    parameter int W      = 4,
    parameter int WRAP_W = 8,
    parameter int CYC_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    counter_checker_if.slave  obs,
    output logic              armed_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [W-1:0]      err_exp_o,
    output logic [W-1:0]      err_got_o,
    output logic [CYC_W-1:0]  err_cyc_o,
    output logic [WRAP_W-1:0] wrap_cnt_o
);

    localparam logic [W-1:0]      CNT_MAX  = {W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
    localparam logic [CYC_W-1:0]  CYC_MAX  = {CYC_W{1'b1}};

    localparam logic [1:0] CODE_RST = 2'b01;
    localparam logic [1:0] CODE_SC  = 2'b10;
    localparam logic [1:0] CODE_INC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_ERROR = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic                p_rst_n_q, p_sc_q;
    logic [W-1:0]        p_cnt_q;
    logic                armed_q, armed_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic [W-1:0]        exp_q, exp_d;
    logic [W-1:0]        got_q, got_d;
    logic [CYC_W-1:0]    ecyc_q, ecyc_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [WRAP_W-1:0]   wrap_q, wrap_d;

    logic [W-1:0]        exp_s;
    logic [1:0]          rule_s;
    logic                mismatch_s;
    logic                wrap_ev_s;

    // Prediction from the previous sample: reset beats shortcut beats increment.
    always_comb begin
        exp_s  = '0;
        rule_s = CODE_INC;
        if (!p_rst_n_q) begin
            exp_s  = '0;
            rule_s = CODE_RST;
        end else if (p_sc_q) begin
            exp_s  = CNT_MAX;
            rule_s = CODE_SC;
        end else begin
            exp_s  = p_cnt_q + W'(1);
            rule_s = CODE_INC;
        end
    end

    assign mismatch_s = (obs.cnt != exp_s);
    assign wrap_ev_s  = (state_q != ST_IDLE) && p_rst_n_q && !p_sc_q &&
                        (p_cnt_q == CNT_MAX) && (obs.cnt == '0);

    // Next-state, first-error diagnostic capture and saturating counters.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        err_d   = err_q;
        code_d  = code_q;
        exp_d   = exp_q;
        got_d   = got_q;
        ecyc_d  = ecyc_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_TRACK;
                armed_d = 1'b1;
            end
            ST_TRACK: begin
                if (mismatch_s) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                    code_d  = rule_s;
                    exp_d   = exp_s;
                    got_d   = obs.cnt;
                    ecyc_d  = cyc_q;
                end else begin
                    state_d = ST_TRACK;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
                armed_d = 1'b0;
            end
        endcase

        if (wrap_ev_s && (wrap_q != WRAP_MAX)) begin
            wrap_d = wrap_q + WRAP_W'(1);
        end else begin
            wrap_d = wrap_q;
        end

        if (cyc_q != CYC_MAX) begin
            cyc_d = cyc_q + CYC_W'(1);
        end else begin
            cyc_d = cyc_q;
        end
    end

    // State, sample and diagnostic registers; rst clears everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            p_rst_n_q <= 1'b0;
            p_sc_q    <= 1'b0;
            p_cnt_q   <= '0;
            armed_q   <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
            exp_q     <= '0;
            got_q     <= '0;
            ecyc_q    <= '0;
            cyc_q     <= '0;
            wrap_q    <= '0;
        end else begin
            state_q   <= state_d;
            p_rst_n_q <= obs.dut_rst_n;
            p_sc_q    <= obs.shortcut;
            p_cnt_q   <= obs.cnt;
            armed_q   <= armed_d;
            err_q     <= err_d;
            code_q    <= code_d;
            exp_q     <= exp_d;
            got_q     <= got_d;
            ecyc_q    <= ecyc_d;
            cyc_q     <= cyc_d;
            wrap_q    <= wrap_d;
        end
    end

    assign armed_o    = armed_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;
    assign err_exp_o  = exp_q;
    assign err_got_o  = got_q;
    assign err_cyc_o  = ecyc_q;
    assign wrap_cnt_o = wrap_q;

`ifdef COUNTER_CHECKER_ASSERT_EN
    logic sc_from_zero_s;
    assign sc_from_zero_s = (state_q != ST_IDLE) && p_rst_n_q && p_sc_q &&
                            (p_cnt_q == '0);

    // Output must match the prediction while tracking.
    always @(posedge clk_i) begin
        if (!rst_i && (state_q == ST_TRACK)) begin
            assert (obs.cnt == exp_s)
            else $error("counter_checker: cnt=%0d exp=%0d err_code=%0b",
                        obs.cnt, exp_s, rule_s);
        end
    end

    // Coverage of a wrap event and of a shortcut taken from zero.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            cover (wrap_ev_s);
            cover (sc_from_zero_s);
        end
    end
`else
    // No assertions or covers in this build.
`endif

endmodule : counter_checker
